// File: rtl/pipeline_pkg.sv
// Shared definitions for the stream blocks: stage limits and count sizing.
package pipeline_pkg;

  // Deepest pipeline any stream block is expected to build.
  localparam int MAX_STAGES = 64;

  // Bits needed to hold an occupancy count from 0 up to and including stages.
  function automatic int count_width(input int stages);
    return (stages < 1) ? 1 : $clog2(stages + 1);
  endfunction

endpackage

// File: rtl/pipe_stage.sv
// One elastic pipeline stage: payload register plus occupancy flag.
// The payload follows the load enable even during a flush; only the
// occupancy flag is cleared, so stale payload is harmless.
module pipe_stage #(
  parameter int WIDTH = 1
) (
  input  logic             clk_in,
  input  logic             rst_n_in,
  input  logic             flush,
  input  logic             load_en,
  input  logic [WIDTH-1:0] data_src,
  input  logic             valid_src,
  output logic [WIDTH-1:0] data_q,
  output logic             valid_q
);

  logic [WIDTH-1:0] data_reg;
  logic             valid_reg;

  // Load from upstream when advancing; flush wins over the load for occupancy.
  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      data_reg  <= '0;
      valid_reg <= 1'b0;
    end else begin
      if (load_en) begin
        data_reg  <= data_src;
        valid_reg <= valid_src;
      end
      if (flush) begin
        valid_reg <= 1'b0;
      end
    end
  end

  assign data_q  = data_reg;
  assign valid_q = valid_reg;

endmodule

// File: rtl/pipeline_elastic.sv
// Elastic valid/ready register pipeline with bubble collapsing, flush and
// an occupancy counter. Every stage can advance in the same cycle, so a
// full pipe still passes one beat per cycle while the sink is ready.
module pipeline_elastic
  import pipeline_pkg::*;
#(
  parameter int STAGES = 1,
  parameter int WIDTH  = 1
) (
  input  logic                            clk_in,
  input  logic                            rst_n_in,
  input  logic [WIDTH-1:0]                data_in,
  input  logic                            valid_in,
  output logic                            ready_out,
  input  logic                            flush_in,
  output logic [WIDTH-1:0]                data_out,
  output logic                            valid_out,
  input  logic                            ready_in,
  output logic [count_width(STAGES)-1:0]  count_out
);

  localparam int CW = count_width(STAGES);

  generate
    if (STAGES < 1 || STAGES > MAX_STAGES) begin : g_bad_stages
      $error("pipeline_elastic: STAGES must lie in 1..64");
    end
  endgenerate

  logic [WIDTH-1:0]  stage_data [STAGES];
  logic [WIDTH-1:0]  src_data   [STAGES];
  logic [STAGES-1:0] stage_valid;
  logic [STAGES-1:0] src_valid;
  logic [STAGES-1:0] stage_adv;
  logic              in_xfer;
  logic              out_xfer;
  logic [CW-1:0]     count_reg;
  logic [CW-1:0]     count_next;

  // A stage may advance unless it and every stage after it is occupied and
  // the sink is stalled. Written as a suffix AND rather than a ripple chain
  // so there is no combinational dependence between bits of stage_adv.
  genvar gi;
  generate
    for (gi = 0; gi < STAGES; gi++) begin : g_stage
      assign stage_adv[gi] = ready_in || !(&stage_valid[STAGES-1:gi]);

      if (gi == 0) begin : g_head
        assign src_data[gi]  = data_in;
        assign src_valid[gi] = valid_in && !flush_in;
      end else begin : g_body
        assign src_data[gi]  = stage_data[gi-1];
        assign src_valid[gi] = stage_valid[gi-1];
      end

      pipe_stage #(
        .WIDTH(WIDTH)
      ) u_stage (
        .clk_in   (clk_in),
        .rst_n_in (rst_n_in),
        .flush    (flush_in),
        .load_en  (stage_adv[gi]),
        .data_src (src_data[gi]),
        .valid_src(src_valid[gi]),
        .data_q   (stage_data[gi]),
        .valid_q  (stage_valid[gi])
      );
    end
  endgenerate

  assign ready_out = stage_adv[0] && !flush_in && rst_n_in;
  assign data_out  = stage_data[STAGES-1];
  assign valid_out = stage_valid[STAGES-1];
  assign in_xfer   = valid_in && ready_out;
  assign out_xfer  = valid_out && ready_in;
  assign count_out = count_reg;

  // Occupancy tracks accepted minus delivered beats; flush empties the pipe.
  always_comb begin
    count_next = count_reg;
    if (flush_in) begin
      count_next = '0;
    end else if (in_xfer && !out_xfer) begin
      count_next = count_reg + CW'(1);
    end else if (!in_xfer && out_xfer) begin
      count_next = count_reg - CW'(1);
    end
  end

  // Occupancy counter register.
  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_next;
    end
  end

endmodule

// File: tb/tb_pipeline_elastic.sv
// Scoreboard bench for pipeline_elastic with STAGES=3, WIDTH=8.
module tb_pipeline_elastic;

  localparam int STAGES = 3;
  localparam int WIDTH  = 8;

  logic             clk_in = 1'b0;
  logic             rst_n_in;
  logic [WIDTH-1:0] data_in;
  logic             valid_in;
  logic             ready_out;
  logic             flush_in;
  logic [WIDTH-1:0] data_out;
  logic             valid_out;
  logic             ready_in;
  logic [1:0]       count_out;

  pipeline_elastic #(
    .STAGES(STAGES),
    .WIDTH (WIDTH)
  ) dut (
    .clk_in   (clk_in),
    .rst_n_in (rst_n_in),
    .data_in  (data_in),
    .valid_in (valid_in),
    .ready_out(ready_out),
    .flush_in (flush_in),
    .data_out (data_out),
    .valid_out(valid_out),
    .ready_in (ready_in),
    .count_out(count_out)
  );

  always #5 clk_in = ~clk_in;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int n_out    = 0;
  int acc_cyc [256];
  int out_cyc [256];

  logic [7:0] exp_q [$];   // beats accepted and not yet delivered
  logic [7:0] src_q [$];   // beats the source still wants to send

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end else begin
      n_pass++;
    end
  endtask

  // One clock cycle: drive source, check handshakes, update scoreboard.
  task automatic run_cycle();
    logic       exp_ready;
    logic       do_in;
    logic       do_out;
    logic [7:0] exp_d;
    valid_in = (src_q.size() != 0);
    data_in  = (src_q.size() != 0) ? src_q[0] : 8'h00;
    #1;
    check_eq("count", 32'(count_out), 32'(exp_q.size()));
    if (exp_q.size() == 0) check_eq("empty_valid", 32'(valid_out), 32'd0);
    exp_ready = rst_n_in && !flush_in && ((exp_q.size() < STAGES) || ready_in);
    check_eq("ready", 32'(ready_out), 32'(exp_ready));
    do_in  = valid_in && exp_ready;
    do_out = valid_out && ready_in && rst_n_in;
    if (do_out) begin
      if (exp_q.size() == 0) begin
        check_eq("spurious_beat", 32'(data_out), 32'hFFFF_FFFF);
      end else begin
        exp_d = exp_q.pop_front();
        check_eq("data", 32'(data_out), 32'(exp_d));
        out_cyc[data_out] = cyc;
        n_out++;
        $display("cycle %0d: beat out 0x%02h", cyc, data_out);
      end
    end
    if (do_in) begin
      acc_cyc[data_in] = cyc;
      void'(src_q.pop_front());
    end
    @(posedge clk_in);
    if (!rst_n_in || flush_in) exp_q.delete();
    else if (do_in) exp_q.push_back(data_in);
    cyc++;
    @(negedge clk_in);
  endtask

  task automatic run_cycles(input int n);
    for (int i = 0; i < n; i++) run_cycle();
  endtask

  int base;

  initial begin
    rst_n_in = 1'b0;
    flush_in = 1'b0;
    ready_in = 1'b0;
    valid_in = 1'b0;
    data_in  = 8'h00;
    @(negedge clk_in);
    run_cycles(2);
    check_eq("reset_valid", 32'(valid_out), 32'd0);
    check_eq("reset_data", 32'(data_out), 32'd0);
    rst_n_in = 1'b1;

    // Streaming 0x01..0x10 with the sink always ready.
    ready_in = 1'b1;
    for (int d = 1; d <= 16; d++) src_q.push_back(8'(d));
    run_cycles(22);
    check_eq("stream_latency", 32'(out_cyc[1] - acc_cyc[1]), 32'd3);
    for (int d = 2; d <= 16; d++) check_eq("stream_gap", 32'(out_cyc[d] - out_cyc[d-1]), 32'd1);
    check_eq("stream_count", 32'(n_out), 32'd16);

    // Full-pipe stall.
    ready_in = 1'b0;
    src_q = '{8'h11, 8'h22, 8'h33, 8'h44};
    run_cycles(5);
    #1;
    check_eq("stall_count", 32'(count_out), 32'd3);
    check_eq("stall_ready", 32'(ready_out), 32'd0);
    check_eq("stall_data", 32'(data_out), 32'h11);
    check_eq("stall_valid", 32'(valid_out), 32'd1);
    base = n_out;
    ready_in = 1'b1;
    run_cycles(8);
    check_eq("stall_drained", 32'(n_out - base), 32'd4);

    // Bubble collapse: one beat reaches the last stage while stalled.
    ready_in = 1'b0;
    src_q = '{8'hAA};
    run_cycles(3);
    #1;
    check_eq("bubble_valid", 32'(valid_out), 32'd1);
    check_eq("bubble_data", 32'(data_out), 32'hAA);
    src_q = '{8'hBB, 8'hCC};
    run_cycles(2);
    check_eq("bubble_accepted", 32'(src_q.size()), 32'd0);
    check_eq("bubble_count", 32'(count_out), 32'd3);
    ready_in = 1'b1;
    run_cycles(5);

    // Flush with two beats in flight and a beat offered at the same time.
    ready_in = 1'b0;
    src_q = '{8'hD1, 8'hD2};
    run_cycles(2);
    check_eq("flush_pre_count", 32'(count_out), 32'd2);
    src_q = '{8'h55};
    flush_in = 1'b1;
    run_cycle();
    flush_in = 1'b0;
    src_q.delete();
    check_eq("flush_count", 32'(count_out), 32'd0);
    check_eq("flush_valid", 32'(valid_out), 32'd0);
    ready_in = 1'b1;
    base = n_out;
    run_cycles(5);
    check_eq("flush_no_beat", 32'(n_out - base), 32'd0);

    // Flush while the last stage is delivering: that beat still leaves.
    ready_in = 1'b0;
    src_q = '{8'hE1, 8'hE2, 8'hE3};
    run_cycles(3);
    base = n_out;
    ready_in = 1'b1;
    flush_in = 1'b1;
    run_cycle();
    flush_in = 1'b0;
    check_eq("flush_out_done", 32'(n_out - base), 32'd1);
    run_cycles(4);
    check_eq("flush_out_rest", 32'(n_out - base), 32'd1);

    // Reset mid-stream with a full pipe.
    ready_in = 1'b0;
    src_q = '{8'hF1, 8'hF2, 8'hF3};
    run_cycles(3);
    check_eq("rst_pre_count", 32'(count_out), 32'd3);
    rst_n_in = 1'b0;
    run_cycle();
    check_eq("rst_mid_valid", 32'(valid_out), 32'd0);
    check_eq("rst_mid_data", 32'(data_out), 32'd0);
    check_eq("rst_mid_count", 32'(count_out), 32'd0);
    rst_n_in = 1'b1;
    ready_in = 1'b1;
    src_q = '{8'h61};
    run_cycles(6);
    check_eq("rst_latency", 32'(out_cyc[8'h61] - acc_cyc[8'h61]), 32'd3);

    // Full pass-through: pipe full, sink ready, source streaming.
    ready_in = 1'b0;
    src_q = '{8'h70, 8'h71, 8'h72};
    run_cycles(3);
    ready_in = 1'b1;
    for (int d = 8'h73; d <= 8'h7C; d++) src_q.push_back(8'(d));
    base = n_out;
    for (int i = 0; i < 10; i++) begin
      #1;
      check_eq("pass_ready", 32'(ready_out), 32'd1);
      check_eq("pass_count", 32'(count_out), 32'd3);
      run_cycle();
    end
    check_eq("pass_beats", 32'(n_out - base), 32'd10);
    run_cycles(5);
    check_eq("final_empty", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/pipeline_elastic.md
PIPELINE_ELASTIC -- requirements
Module: pipeline_elastic

Interface
REQ-001 SHALL have parameter STAGES, default 1, meaning the number of register stages, with a legal range of 1..64.
REQ-002 SHALL have parameter WIDTH, default 1, meaning the payload bit width, with a legal range of 1 or more.
REQ-003 SHALL have port clk_in, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 SHALL have port rst_n_in, input, 1 bit: reset, synchronous and active-low.
REQ-005 SHALL have port data_in, input, WIDTH bits: the upstream payload.
REQ-006 SHALL have port valid_in, input, 1 bit: the upstream beat is valid.
REQ-007 SHALL have port ready_out, output, 1 bit: the block accepts a beat this cycle.
REQ-008 SHALL have port flush_in, input, 1 bit: discard all in-flight beats.
REQ-009 SHALL have port data_out, output, WIDTH bits: the payload of the last stage.
REQ-010 SHALL have port valid_out, output, 1 bit: the last stage holds a beat.
REQ-011 SHALL have port ready_in, input, 1 bit: the downstream accepts the beat.
REQ-012 SHALL have port count_out, output, $clog2(STAGES+1) bits: the number of occupied stages.

Function
REQ-013 SHALL hold, per stage i (0..STAGES-1), a data register d[i] and an occupancy flag v[i]; data_out = d[STAGES-1] and valid_out = v[STAGES-1].
REQ-014 SHALL define a beat transfer as valid && ready on the same edge: in = valid_in && ready_out; out = valid_out && ready_in.
REQ-015 SHALL compute stage-advance enables combinationally: adv[STAGES-1] = !v[STAGES-1] || ready_in; adv[i] = !v[i] || adv[i+1]; ready_out = adv[0] && !flush_in.
REQ-016 SHALL, when adv[i] is high, load d[i]/v[i] from stage i-1 (for stage 0, from data_in / valid_in && !flush_in); when adv[i] is low, stage i holds.
REQ-017 SHALL collapse bubbles: an empty stage accepts from upstream even while downstream stalls.
REQ-018 SHALL have a latency of exactly STAGES cycles from the in transfer to the first cycle valid_out is high, with no stalls and an empty pipe.
REQ-019 SHALL sustain a throughput of one beat per cycle whenever ready_in is held high, including when all stages are occupied.
REQ-020 SHALL keep data_out stable while valid_out is high and ready_in is low, and never drop, duplicate or reorder a beat.
REQ-021 SHALL have count_out as a register equal to the popcount of v; it updates +1 on in-only, -1 on out-only, and is unchanged on both or neither.
REQ-022 SHALL treat count_out = STAGES with ready_in low as full: ready_out is low.
REQ-023 SHALL treat count_out = 0 as empty: valid_out is low.
REQ-024 SHALL, on flush_in high, clear all v[i] and set count_out to 0 at the next edge; the concurrent valid_in beat is dropped (ready_out low) and the concurrent out transfer still completes.
REQ-025 SHALL give flush_in priority over all stage loads; d[i] may retain stale values after a flush.

Reset
REQ-026 SHALL, on rst_n_in low at a clock edge, clear every v[i], d[i] and count_out to 0, so that valid_out=0, data_out=0 and count_out=0 at the next cycle.
REQ-027 SHALL give reset priority over flush_in and all transfers; beats in flight when reset is asserted mid-stream are discarded.
REQ-028 SHALL drive ready_out low while rst_n_in is low.

Structure
REQ-029 SHALL define the count-width constant function in the shared package pipeline_pkg, for reuse by the other stream blocks.
REQ-030 SHALL implement one stage as sub-module pipe_stage (d/v register with load enable, flush and reset), instantiated STAGES times by a generate loop.
REQ-031 SHALL fail elaboration when STAGES < 1.

Verification (STAGES=3, WIDTH=8)
REQ-032 SHALL cover streaming: valid_in=1 with 0x01..0x10 and ready_in=1 -> 0x01 on data_out 3 cycles after its acceptance, then 0x02..0x10 on consecutive cycles, no gaps.
REQ-033 SHALL cover a full-pipe stall: 0x11,0x22,0x33,0x44 offered, ready_in=0 -> count_out=3, ready_out=0, data_out=0x11 held; after ready_in=1, the order is 0x11,0x22,0x33,0x44.
REQ-034 SHALL cover bubble collapse: a single beat 0xAA, then ready_in=0 -> 0xAA at the last stage after 3 cycles; 0xBB and 0xCC are then still accepted, count_out=3.
REQ-035 SHALL cover flush: count_out=2 with flush_in=1 and valid_in=1 (0x55) -> next cycle count_out=0, valid_out=0, and 0x55 never appears.
REQ-036 SHALL cover reset mid-stream: rst_n_in=0 with count_out=3 -> next cycle valid_out=0, data_out=0x00, count_out=0; after release, new beats emerge with 3-cycle latency.
REQ-037 SHALL cover full pass-through: count_out=3, ready_in=1, valid_in=1 for 10 cycles -> ready_out=1 and count_out=3 throughout, 10 beats out in order.
